// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch queue.
// Entry layout is {pc, instr}; widths follow the default core configuration.
package fetch_pkg;

    localparam int FQ_DATA = 32;
    localparam int FQ_ADDR = 32;
    localparam int FQ_DEPTH = 8;
    localparam logic [FQ_ADDR-1:0] FQ_RESET_PC = '0;

    typedef enum logic [1:0] {
        RUN,
        MISS,
        FULL,
        DRAIN
    } fq_state_t;

    typedef struct packed {
        logic [FQ_ADDR-1:0] pc;
        logic [FQ_DATA-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Circular-buffer storage for the fetch queue: two write and two read ports.
// Data is not reset; occupancy tracking in the parent qualifies every read.
module fq_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     CLK,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wa0,
    input  logic [$clog2(DEPTH)-1:0] wa1,
    input  fq_entry_t                wd0,
    input  fq_entry_t                wd1,
    input  logic [$clog2(DEPTH)-1:0] ra0,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    output fq_entry_t                rd0,
    output fq_entry_t                rd1
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: pairs of instructions from the I$ into a 2-in/2-out FIFO.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency bypass into an empty queue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DATA     = FQ_DATA,
    parameter int              ADDR     = FQ_ADDR,
    parameter int              DEPTH    = FQ_DEPTH,
    parameter logic [ADDR-1:0] RESET_PC = FQ_RESET_PC
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SYS,
    input  logic                   redirect,
    input  logic [ADDR-1:0]        redirect_pc,
    output logic [ADDR-1:0]        ic_address,
    output logic                   ic_dread,
    input  logic [DATA-1:0]        ic_data1,
    input  logic [DATA-1:0]        ic_data2,
    input  logic                   ic_busy,
    output logic [1:0]             deq_valid,
    output logic [DATA-1:0]        deq_instr0,
    output logic [DATA-1:0]        deq_instr1,
    output logic [ADDR-1:0]        deq_pc0,
    output logic [ADDR-1:0]        deq_pc1,
    input  logic [1:0]             deq_take,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_state_t       state, state_n;
    logic [ADDR-1:0] pc, pc_n, redir_q, redir_n, target;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_n;
    logic            accept, byp, full_n;
    logic [1:0]      take_req, nvalid, take_eff, skip, push_n;
    logic            we0, we1;
    fq_entry_t       ent0, ent1, wd0, wd1, rd0, rd1;
    logic            unused_lo;

    assign target     = {redirect_pc[ADDR-1:2], 2'b00};
    assign unused_lo  = ^redirect_pc[1:0];
    assign ic_address = pc;

    assign ent0.pc    = pc;
    assign ent0.instr = ic_data1;
    assign ent1.pc    = pc + ADDR'(4);
    assign ent1.instr = ic_data2;

    always_comb begin
        ic_dread = 1'b0;
        if (!RESET) begin
            unique case (state)
                RUN:         ic_dread = !SYS && !redirect;
                MISS, DRAIN: ic_dread = 1'b1;
                default:     ic_dread = 1'b0;
            endcase
        end
    end

    assign accept = ic_dread && !ic_busy && !redirect &&
                    (state == RUN || state == MISS);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = accept && (count == '0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        deq_valid = {count >= CW'(2), count >= CW'(1)};
        if (byp) deq_valid = 2'b11;
        if (RESET) deq_valid = 2'b00;
    end

    assign nvalid   = deq_valid[1] ? 2'd2 : {1'b0, deq_valid[0]};
    assign take_req = (deq_take == 2'd3) ? 2'd2 : deq_take;

    always_comb begin
        take_eff = (take_req > nvalid) ? nvalid : take_req;
        if (redirect || RESET) take_eff = 2'd0;
    end

    // Bypassed entries that are consumed at once never touch storage
    assign skip    = byp ? take_eff : 2'd0;
    assign push_n  = accept ? (2'd2 - skip) : 2'd0;
    assign count_n = count + (accept ? CW'(2) : CW'(0)) - CW'(take_eff);
    assign full_n  = count_n > CW'(DEPTH - 2);

    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wd0 = ent0;
        wd1 = ent1;
        unique case (1'b1)
            (!accept || skip == 2'd2): ;
            (skip == 2'd1): begin
                we0 = 1'b1;
                wd0 = ent1;
            end
            default: begin
                we0 = 1'b1;
                we1 = 1'b1;
            end
        endcase
    end

    fq_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .CLK(CLK),
        .we0(we0),
        .we1(we1),
        .wa0(wr_ptr),
        .wa1(wr_ptr + PW'(1)),
        .wd0(wd0),
        .wd1(wd1),
        .ra0(rd_ptr),
        .ra1(rd_ptr + PW'(1)),
        .rd0(rd0),
        .rd1(rd1)
    );

    assign deq_pc0    = byp ? ent0.pc    : rd0.pc;
    assign deq_pc1    = byp ? ent1.pc    : rd1.pc;
    assign deq_instr0 = byp ? ent0.instr : rd0.instr;
    assign deq_instr1 = byp ? ent1.instr : rd1.instr;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        redir_n = redir_q;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    pc_n = target;
                end else if (ic_dread && ic_busy) begin
                    state_n = MISS;
                end else if (accept) begin
                    pc_n = pc + ADDR'(8);
                    if (full_n) state_n = FULL;
                end
            end
            MISS: begin
                if (redirect) begin
                    redir_n = target;
                    state_n = DRAIN;
                end else if (!ic_busy) begin
                    pc_n    = pc + ADDR'(8);
                    state_n = full_n ? FULL : RUN;
                end
            end
            FULL: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = RUN;
                end else if (!full_n) begin
                    state_n = RUN;
                end
            end
            DRAIN: begin
                // The outstanding miss must finish before the new PC issues
                if (redirect) redir_n = target;
                if (!ic_busy) begin
                    pc_n    = redirect ? target : redir_q;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= RUN;
            pc      <= RESET_PC;
            redir_q <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            redir_q <= redir_n;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count_n;
                rd_ptr <= rd_ptr + PW'(take_eff - skip);
                wr_ptr <= wr_ptr + PW'(push_n);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed fetch, miss, full,
// redirect and over-take sequences against an I$ model.
module tb_fetch_queue;

    logic        CLK;
    logic        RESET;
    logic        SYS;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ic_address;
    logic        ic_dread;
    logic [31:0] ic_data1;
    logic [31:0] ic_data2;
    logic        ic_busy;
    logic [1:0]  deq_valid;
    logic [31:0] deq_instr0;
    logic [31:0] deq_instr1;
    logic [31:0] deq_pc0;
    logic [31:0] deq_pc1;
    logic [1:0]  deq_take;
    logic [3:0]  count;
    logic        busy_force;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sb[$];
    logic [31:0] pend[$];
    logic        flush_pend = 1'b0;

    fetch_queue dut (
        .CLK(CLK),
        .RESET(RESET),
        .SYS(SYS),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .ic_address(ic_address),
        .ic_dread(ic_dread),
        .ic_data1(ic_data1),
        .ic_data2(ic_data2),
        .ic_busy(ic_busy),
        .deq_valid(deq_valid),
        .deq_instr0(deq_instr0),
        .deq_instr1(deq_instr1),
        .deq_pc0(deq_pc0),
        .deq_pc1(deq_pc1),
        .deq_take(deq_take),
        .count(count)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign ic_data1 = instr_of(ic_address);
    assign ic_data2 = instr_of(ic_address + 32'd4);
    assign ic_busy  = busy_force & ic_dread;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pair(input logic [31:0] pc);
        pend.push_back(pc);
        pend.push_back(pc + 32'd4);
    endtask

    task automatic cyc(input logic rst, input logic sys, input logic rd,
                       input logic [31:0] rpc, input logic busy,
                       input logic [1:0] take);
        @(posedge CLK);
        #1;
        if (flush_pend) begin
            sb.delete();
            flush_pend = 1'b0;
        end
        while (pend.size() > 0) sb.push_back(pend.pop_front());
        RESET       = rst;
        SYS         = sys;
        redirect    = rd;
        redirect_pc = rpc;
        busy_force  = busy;
        deq_take    = take;
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin : mon
        int n;
        int t;
        logic [31:0] e;
        if (!RESET) begin
            n = (sb.size() >= 2) ? 2 : sb.size();
            chk("deq_valid", 32'(deq_valid),
                (n == 2) ? 32'd3 : (n == 1) ? 32'd1 : 32'd0);
            if (!redirect) begin
                t = (deq_take == 2'd3) ? 2 : int'(deq_take);
                if (t > n) t = n;
                if (t >= 1) begin
                    e = sb.pop_front();
                    chk("deq_pc0", deq_pc0, e);
                    chk("deq_instr0", deq_instr0, instr_of(e));
                end
                if (t >= 2) begin
                    e = sb.pop_front();
                    chk("deq_pc1", deq_pc1, e);
                    chk("deq_instr1", deq_instr1, instr_of(e));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        RESET       = 1'b1;
        SYS         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        busy_force  = 1'b0;
        deq_take    = 2'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dread", 32'(ic_dread), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // Hit stream with full dequeue every cycle
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0, 0, 2'd2);
            chk("hit_addr", ic_address, 32'(8 * k));
            chk("hit_dread", 32'(ic_dread), 32'd1);
            chk("hit_count", 32'(count), (k == 0) ? 32'd0 : 32'd2);
            expect_pair(32'(8 * k));
        end
        cyc(0, 1, 0, 0, 0, 2'd2);
        chk("sys_dread", 32'(ic_dread), 32'd0);
        chk("sys_addr", ic_address, 32'h30);
        cyc(0, 1, 0, 0, 0, 2'd0);
        chk("sys_count", 32'(count), 32'd0);
        chk("sys_hold", ic_address, 32'h30);

        // Ten-cycle miss at 0x40
        cyc(0, 0, 0, 0, 0, 2'd2);
        expect_pair(32'h30);
        cyc(0, 0, 0, 0, 0, 2'd2);
        expect_pair(32'h38);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, (i == 0) ? 2'd2 : 2'd0);
            chk("miss_addr", ic_address, 32'h40);
            chk("miss_dread", 32'(ic_dread), 32'd1);
        end
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("miss_done", ic_address, 32'h40);
        expect_pair(32'h40);
        cyc(0, 1, 0, 0, 0, 2'd0);
        chk("miss_count", 32'(count), 32'd2);
        chk("miss_next", ic_address, 32'h48);
        cyc(0, 1, 0, 0, 0, 2'd2);

        // Fill to DEPTH, then release two slots
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 2'd0);
            chk("fill_count", 32'(count), 32'(2 * k));
            expect_pair(32'h48 + 32'(8 * k));
        end
        cyc(0, 0, 0, 0, 0, 2'd2);
        chk("full_count", 32'(count), 32'd8);
        chk("full_dread", 32'(ic_dread), 32'd0);
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("unfull_dread", 32'(ic_dread), 32'd1);
        chk("unfull_addr", ic_address, 32'h68);
        chk("unfull_count", 32'(count), 32'd6);
        expect_pair(32'h68);
        cyc(0, 1, 0, 0, 0, 2'd2);
        chk("refull_count", 32'(count), 32'd8);
        chk("refull_dread", 32'(ic_dread), 32'd0);

        // Redirect in RUN with six entries queued
        cyc(0, 0, 1, 32'h1003, 0, 2'd2);
        chk("redir_count", 32'(count), 32'd6);
        chk("redir_dread", 32'(ic_dread), 32'd0);
        flush_pend = 1'b1;
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("redir_flush", 32'(count), 32'd0);
        chk("redir_addr", ic_address, 32'h1000);
        expect_pair(32'h1000);

        // Redirect on the third cycle of a miss
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, (i == 2), 32'h200, 1, 2'd0);
            chk("drain_addr", ic_address, 32'h1008);
            chk("drain_dread", 32'(ic_dread), 32'd1);
            if (i == 2) flush_pend = 1'b1;
        end
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("drain_last", ic_address, 32'h1008);
        cyc(0, 1, 0, 0, 0, 2'd0);
        chk("drain_pc", ic_address, 32'h200);
        chk("drain_count", 32'(count), 32'd0);

        // Over-take with one and then two valid entries
        cyc(0, 0, 0, 0, 0, 2'd0);
        expect_pair(32'h200);
        cyc(0, 1, 0, 0, 0, 2'd1);
        chk("take1_count", 32'(count), 32'd2);
        cyc(0, 1, 0, 0, 0, 2'd2);
        chk("over_count", 32'(count), 32'd1);
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("over_empty", 32'(count), 32'd0);
        chk("over_addr", ic_address, 32'h208);
        expect_pair(32'h208);
        cyc(0, 1, 0, 0, 0, 2'd3);
        chk("take3_count", 32'(count), 32'd2);
        cyc(0, 1, 0, 0, 0, 2'd0);
        chk("take3_empty", 32'(count), 32'd0);

        // Reset in the middle of a miss
        cyc(0, 0, 0, 0, 1, 2'd0);
        chk("rmiss_addr", ic_address, 32'h210);
        cyc(1, 0, 0, 0, 1, 2'd0);
        chk("rmiss_dread", 32'(ic_dread), 32'd0);
        chk("rmiss_valid", 32'(deq_valid), 32'd0);
        flush_pend = 1'b1;
        cyc(0, 0, 0, 0, 0, 2'd0);
        chk("rst_pc", ic_address, 32'h0);
        chk("rst_cnt2", 32'(count), 32'd0);
        chk("rst_fetch", 32'(ic_dread), 32'd1);
        expect_pair(32'h0);
        cyc(0, 1, 0, 0, 0, 2'd2);
        chk("end_count", 32'(count), 32'd2);
        cyc(0, 1, 0, 0, 0, 2'd0);
        chk("end_empty", 32'(count), 32'd0);
        chk("sb_empty", 32'(sb.size() + pend.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
